// File: rtl/uart_rx_v2_if.sv
// Host-side bundle of uart_rx_v2: received word, error flags and the
// valid/ready pop handshake.
//   master : receiver side (drives rx_valid, dout, e_*; samples rd_ready, clear_err)
//   slave  : consumer side (samples word and flags; drives rd_ready, clear_err)
interface uart_rx_v2_if #(
  parameter int unsigned DBIT_MAX = 9
) ();
  logic                rx_valid;
  logic                rd_ready;
  logic                clear_err;
  logic [DBIT_MAX-1:0] dout;
  logic                e_parity;
  logic                e_frame;
  logic                e_break;
  logic                e_overrun;

  modport master (
    output rx_valid, dout, e_parity, e_frame, e_break, e_overrun,
    input  rd_ready, clear_err
  );

  modport slave (
    input  rx_valid, dout, e_parity, e_frame, e_break, e_overrun,
    output rd_ready, clear_err
  );
endinterface

// File: rtl/uart_rx_v2.sv
// UART receiver: 5..DBIT_MAX data bits, none/even/odd parity, configurable
// oversample and stop-bit tick counts. Rejects false starts, detects breaks,
// and presents each frame in a valid/ready holding register with sticky overrun.
// Optional feature macro: UART_RX_MAJORITY_EN (2-of-3 majority bit sampling).
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   rx               serial line (asynchronous, idle high)
//   s_tick           oversample strobe, one clk wide
//   dbit, pbit       data-bit count (clamped) and parity mode
//   os_tick, sb_tick ticks per bit / ticks for the stop bit
//   busy             receiver not idle
//   host             uart_rx_v2_if master: word, flags, rd_ready/clear_err
module uart_rx_v2 #(
  parameter int unsigned DBIT_MAX = 9,
  parameter int unsigned CFG_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx,
  input  logic             s_tick,
  input  logic [3:0]       dbit,
  input  logic [1:0]       pbit,
  input  logic [CFG_W-1:0] os_tick,
  input  logic [CFG_W-1:0] sb_tick,
  output logic             busy,
  uart_rx_v2_if.master     host
);

  localparam int unsigned DW      = DBIT_MAX;
  localparam logic [3:0]  DBIT_LO = 4'd5;
  localparam logic [3:0]  DBIT_HI = 4'(DBIT_MAX);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} state_t;

  state_t           state_q, state_nxt;
  logic [1:0]       sync_q;
  logic             rx_s;
  logic [CFG_W-1:0] s_q, s_nxt;
  logic [3:0]       n_q, n_nxt;
  logic [DW-1:0]    data_q, data_nxt;
  logic             par_err_q, par_err_nxt;
  logic             par_bit_q, par_bit_nxt;
  logic [3:0]       dbit_q, dbit_nxt;
  logic [1:0]       pbit_q, pbit_nxt;
  logic [CFG_W-1:0] os_q, os_nxt;
  logic [CFG_W-1:0] sb_q, sb_nxt;
  logic             samp_c;
  logic             done_c;
  logic             frame_err_c;
  logic             brk_c;
  logic             pop_c;
  logic [3:0]       dbit_clamp_c;
  logic [CFG_W-1:0] os_last_c;
  logic [CFG_W-1:0] sb_last_c;
  logic [CFG_W-1:0] mid_c;

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], rx};
  end
  assign rx_s = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
  // Last two tick samples; with the current sample they form the 2-of-3 vote.
  logic [1:0] hist_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 hist_q <= 2'b00;
    else if (state_q == IDLE)  hist_q <= 2'b00;
    else if (s_tick)           hist_q <= {hist_q[0], rx_s};
  end
  assign samp_c = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
  assign samp_c = rx_s;
`endif

  assign dbit_clamp_c = (dbit < DBIT_LO) ? DBIT_LO : ((dbit > DBIT_HI) ? DBIT_HI : dbit);
  assign os_last_c    = os_q - CFG_W'(1);
  assign sb_last_c    = sb_q - CFG_W'(1);
  assign mid_c        = os_last_c >> 1;
  assign pop_c        = host.rx_valid & host.rd_ready;

  // Next-state and frame datapath.
  always_comb begin
    state_nxt   = state_q;
    s_nxt       = s_q;
    n_nxt       = n_q;
    data_nxt    = data_q;
    par_err_nxt = par_err_q;
    par_bit_nxt = par_bit_q;
    dbit_nxt    = dbit_q;
    pbit_nxt    = pbit_q;
    os_nxt      = os_q;
    sb_nxt      = sb_q;
    done_c      = 1'b0;
    frame_err_c = 1'b0;
    brk_c       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_nxt   = START;
          s_nxt       = '0;
          n_nxt       = '0;
          data_nxt    = '0;
          par_err_nxt = 1'b0;
          par_bit_nxt = 1'b0;
          dbit_nxt    = dbit_clamp_c;
          pbit_nxt    = pbit;
          os_nxt      = os_tick;
          sb_nxt      = sb_tick;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_q == mid_c) begin
            s_nxt = '0;
            n_nxt = '0;
            state_nxt = samp_c ? IDLE : DATA;
          end else begin
            s_nxt = s_q + CFG_W'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_q == os_last_c) begin
            s_nxt = '0;
            for (int i = 0; i < int'(DW); i++) begin
              if (n_q == 4'(i)) data_nxt[i] = samp_c;
            end
            if (n_q == dbit_q - 4'd1) begin
              state_nxt = (pbit_q == 2'd1 || pbit_q == 2'd2) ? PARITY : STOP;
            end else begin
              n_nxt = n_q + 4'd1;
            end
          end else begin
            s_nxt = s_q + CFG_W'(1);
          end
        end
      end
      PARITY: begin
        if (s_tick) begin
          if (s_q == os_last_c) begin
            s_nxt       = '0;
            par_bit_nxt = samp_c;
            par_err_nxt = samp_c != ((^data_q) ^ (pbit_q == 2'd2));
            state_nxt   = STOP;
          end else begin
            s_nxt = s_q + CFG_W'(1);
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_q == sb_last_c) begin
            s_nxt       = '0;
            done_c      = 1'b1;
            frame_err_c = ~samp_c;
            // Break: every bit of the frame, stop included, was low.
            brk_c       = (data_q == '0) && !par_bit_q && !samp_c;
            state_nxt   = brk_c ? BRK_WAIT : IDLE;
          end else begin
            s_nxt = s_q + CFG_W'(1);
          end
        end
      end
      BRK_WAIT: begin
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM and frame registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      s_q       <= '0;
      n_q       <= '0;
      data_q    <= '0;
      par_err_q <= 1'b0;
      par_bit_q <= 1'b0;
      dbit_q    <= '0;
      pbit_q    <= '0;
      os_q      <= '0;
      sb_q      <= '0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      s_q       <= s_nxt;
      n_q       <= n_nxt;
      data_q    <= data_nxt;
      par_err_q <= par_err_nxt;
      par_bit_q <= par_bit_nxt;
      dbit_q    <= dbit_nxt;
      pbit_q    <= pbit_nxt;
      os_q      <= os_nxt;
      sb_q      <= sb_nxt;
      busy      <= (state_nxt != IDLE);
    end
  end

  // Holding register: a completing frame loads only if the slot is empty or
  // being popped this clk; otherwise it is dropped and overrun is flagged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      host.rx_valid  <= 1'b0;
      host.dout      <= '0;
      host.e_parity  <= 1'b0;
      host.e_frame   <= 1'b0;
      host.e_break   <= 1'b0;
      host.e_overrun <= 1'b0;
    end else begin
      if (done_c && (!host.rx_valid || pop_c)) begin
        host.rx_valid <= 1'b1;
        host.dout     <= data_q;
        host.e_parity <= par_err_q;
        host.e_frame  <= frame_err_c;
        host.e_break  <= brk_c;
      end else if (pop_c) begin
        host.rx_valid <= 1'b0;
      end
      if (done_c && host.rx_valid && !pop_c) host.e_overrun <= 1'b1;
      else if (host.clear_err)               host.e_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_v2.sv
// Directed bench for uart_rx_v2: s_tick every 3 clks, os=16 -> 48 clks per bit.
module tb_uart_rx_v2;
  localparam int unsigned DBIT_MAX = 9;
  localparam int unsigned CFG_W    = 8;
  localparam int          BITC     = 48;

  logic             clk = 1'b0;
  logic             reset;
  logic             rx;
  logic             s_tick;
  logic [3:0]       dbit;
  logic [1:0]       pbit;
  logic [CFG_W-1:0] os_tick;
  logic [CFG_W-1:0] sb_tick;
  logic             busy;
  logic [1:0]       tick_cnt;

  int total = 0;
  int bad   = 0;
  int lat   = 0;

  uart_rx_v2_if #(.DBIT_MAX(DBIT_MAX)) bus ();

  uart_rx_v2 #(.DBIT_MAX(DBIT_MAX), .CFG_W(CFG_W)) dut (
    .clk(clk), .reset(reset), .rx(rx), .s_tick(s_tick), .dbit(dbit), .pbit(pbit),
    .os_tick(os_tick), .sb_tick(sb_tick), .busy(busy), .host(bus)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (reset) tick_cnt <= 2'd0;
    else       tick_cnt <= (tick_cnt == 2'd2) ? 2'd0 : tick_cnt + 2'd1;
  end
  assign s_tick = (tick_cnt == 2'd0) && !reset;

  // Start every frame at the same tick phase so frame latency is repeatable.
  task automatic align();
    @(negedge clk);
    while (tick_cnt != 2'd1) @(negedge clk);
  endtask

  task automatic hold_bit(input logic v, input int clks, input bit glitch);
    if (glitch) begin
      rx = v;  repeat (clks / 2 - 1) @(negedge clk);
      rx = ~v; repeat (3) @(negedge clk);
      rx = v;  repeat (clks - clks / 2 - 2) @(negedge clk);
    end else begin
      rx = v;  repeat (clks) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [8:0] d, input int nb, input bit has_par,
                            input logic pv, input int stop_ticks, input int glitch_bit);
    hold_bit(1'b0, BITC, 1'b0);
    for (int i = 0; i < nb; i++) hold_bit(d[i], BITC, glitch_bit == i);
    if (has_par) hold_bit(pv, BITC, 1'b0);
    hold_bit(1'b1, stop_ticks * 3, 1'b0);
    hold_bit(1'b1, 2 * BITC, 1'b0);
  endtask

  task automatic pop();
    @(negedge clk); bus.rd_ready = 1'b1;
    @(negedge clk); bus.rd_ready = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (bus.rx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.rx_valid); end
    total++; if (bus.dout !== 9'h000) begin bad++; $display("FAIL reset_dout got=%h exp=000", bus.dout); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (bus.e_overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b exp=0", bus.e_overrun); end
  endtask

  task automatic test_8n1();
    int cnt;
    dbit = 4'd8; pbit = 2'd0; os_tick = 8'd16; sb_tick = 8'd16;
    align();
    fork
      send_frame(9'h0A5, 8, 1'b0, 1'b0, 16, -1);
      begin
        cnt = 0;
        while (bus.rx_valid !== 1'b1 && cnt < 3000) begin @(negedge clk); cnt++; end
      end
    join
    lat = cnt;
    total++; if (cnt >= 3000) begin bad++; $display("FAIL 8n1_timeout got=%0d exp=<3000", cnt); end
    total++; if (bus.dout !== 9'h0A5) begin bad++; $display("FAIL 8n1_dout got=%h exp=0a5", bus.dout); end
    total++; if ({bus.e_parity, bus.e_frame, bus.e_break} !== 3'b000) begin bad++;
      $display("FAIL 8n1_errs got=%b exp=000", {bus.e_parity, bus.e_frame, bus.e_break}); end
    pop();
    total++; if (bus.rx_valid !== 1'b0) begin bad++; $display("FAIL 8n1_pop got=%b exp=0", bus.rx_valid); end
  endtask

  task automatic test_parity();
    dbit = 4'd7; pbit = 2'd1;
    align(); send_frame(9'h055, 7, 1'b1, 1'b1, 16, -1);
    total++; if (bus.rx_valid !== 1'b1 || bus.dout !== 9'h055) begin bad++;
      $display("FAIL par_bad_dout got=%b/%h exp=1/055", bus.rx_valid, bus.dout); end
    total++; if (bus.e_parity !== 1'b1) begin bad++; $display("FAIL par_bad_flag got=%b exp=1", bus.e_parity); end
    pop();
    align(); send_frame(9'h055, 7, 1'b1, 1'b0, 16, -1);
    total++; if (bus.rx_valid !== 1'b1 || bus.e_parity !== 1'b0) begin bad++;
      $display("FAIL par_good got=%b/%b exp=1/0", bus.rx_valid, bus.e_parity); end
    pop();
    dbit = 4'd7; pbit = 2'd2;
    align(); send_frame(9'h055, 7, 1'b1, 1'b1, 16, -1);
    total++; if (bus.e_parity !== 1'b0 || bus.dout !== 9'h055) begin bad++;
      $display("FAIL par_odd got=%b/%h exp=0/055", bus.e_parity, bus.dout); end
    pop();
  endtask

  task automatic test_9bit();
    dbit = 4'd9; pbit = 2'd0; sb_tick = 8'd32;
    align(); send_frame(9'h1C3, 9, 1'b0, 1'b0, 32, -1);
    total++; if (bus.rx_valid !== 1'b1 || bus.dout !== 9'h1C3) begin bad++;
      $display("FAIL 9bit_dout got=%b/%h exp=1/1c3", bus.rx_valid, bus.dout); end
    pop();
    align();
    fork
      send_frame(9'h1C3, 9, 1'b0, 1'b0, 32, -1);
      begin repeat (200) @(negedge clk); dbit = 4'd5; end
    join
    total++; if (bus.rx_valid !== 1'b1 || bus.dout !== 9'h1C3) begin bad++;
      $display("FAIL 9bit_shadow got=%b/%h exp=1/1c3", bus.rx_valid, bus.dout); end
    pop();
    dbit = 4'd8; sb_tick = 8'd16;
  endtask

  task automatic test_false_start();
    align();
    rx = 1'b0; repeat (6) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL fs_busy_rise got=%b exp=1", busy); end
    repeat (6) @(negedge clk); rx = 1'b1;
    repeat (200) @(negedge clk);
    total++; if (bus.rx_valid !== 1'b0) begin bad++; $display("FAIL fs_valid got=%b exp=0", bus.rx_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL fs_busy got=%b exp=0", busy); end
  endtask

`ifdef UART_RX_MAJORITY_EN
  task automatic test_majority();
    align(); send_frame(9'h03C, 8, 1'b0, 1'b0, 16, 3);
    total++; if (bus.rx_valid !== 1'b1 || bus.dout !== 9'h03C) begin bad++;
      $display("FAIL maj_glitch got=%b/%h exp=1/03c", bus.rx_valid, bus.dout); end
    pop();
  endtask
`endif

  task automatic test_overrun();
    align(); send_frame(9'h011, 8, 1'b0, 1'b0, 16, -1);
    align(); send_frame(9'h022, 8, 1'b0, 1'b0, 16, -1);
    total++; if (bus.rx_valid !== 1'b1 || bus.dout !== 9'h011) begin bad++;
      $display("FAIL ovr_keep got=%b/%h exp=1/011", bus.rx_valid, bus.dout); end
    total++; if (bus.e_overrun !== 1'b1) begin bad++; $display("FAIL ovr_set got=%b exp=1", bus.e_overrun); end
    @(negedge clk); bus.clear_err = 1'b1; @(negedge clk); bus.clear_err = 1'b0;
    total++; if (bus.e_overrun !== 1'b0 || bus.dout !== 9'h011) begin bad++;
      $display("FAIL ovr_clear got=%b/%h exp=0/011", bus.e_overrun, bus.dout); end
    // Pop lands on the completion clk: new word loads, no overrun.
    align();
    fork
      send_frame(9'h033, 8, 1'b0, 1'b0, 16, -1);
      begin
        repeat (lat - 1) @(negedge clk); bus.rd_ready = 1'b1;
        @(negedge clk); bus.rd_ready = 1'b0;
        total++; if (bus.rx_valid !== 1'b1 || bus.dout !== 9'h033 || bus.e_overrun !== 1'b0) begin bad++;
          $display("FAIL ovr_pop_coincide got=%b/%h/%b exp=1/033/0", bus.rx_valid, bus.dout, bus.e_overrun); end
      end
    join
    // clear_err on the overrun clk: set wins.
    align();
    fork
      send_frame(9'h044, 8, 1'b0, 1'b0, 16, -1);
      begin
        repeat (lat - 1) @(negedge clk); bus.clear_err = 1'b1;
        @(negedge clk); bus.clear_err = 1'b0;
        total++; if (bus.e_overrun !== 1'b1 || bus.dout !== 9'h033) begin bad++;
          $display("FAIL ovr_set_wins got=%b/%h exp=1/033", bus.e_overrun, bus.dout); end
      end
    join
    @(negedge clk); bus.clear_err = 1'b1; @(negedge clk); bus.clear_err = 1'b0;
    pop();
  endtask

  task automatic test_break();
    align();
    rx = 1'b0; repeat (12 * BITC) @(negedge clk);
    total++; if (bus.rx_valid !== 1'b1 || bus.dout !== 9'h000) begin bad++;
      $display("FAIL brk_word got=%b/%h exp=1/000", bus.rx_valid, bus.dout); end
    total++; if ({bus.e_break, bus.e_frame, bus.e_parity} !== 3'b110) begin bad++;
      $display("FAIL brk_flags got=%b exp=110", {bus.e_break, bus.e_frame, bus.e_parity}); end
    total++; if (bus.e_overrun !== 1'b0 || busy !== 1'b1) begin bad++;
      $display("FAIL brk_hold got=%b/%b exp=0/1", bus.e_overrun, busy); end
    rx = 1'b1; repeat (150) @(negedge clk);
    total++; if (busy !== 1'b0 || bus.e_overrun !== 1'b0) begin bad++;
      $display("FAIL brk_release got=%b/%b exp=0/0", busy, bus.e_overrun); end
    pop();
    align(); send_frame(9'h05A, 8, 1'b0, 1'b0, 16, -1);
    total++; if (bus.rx_valid !== 1'b1 || bus.dout !== 9'h05A || bus.e_break !== 1'b0) begin bad++;
      $display("FAIL brk_recover got=%b/%h/%b exp=1/05a/0", bus.rx_valid, bus.dout, bus.e_break); end
    pop();
  endtask

  initial begin
    reset = 1'b1; rx = 1'b1; dbit = 4'd8; pbit = 2'd0; os_tick = 8'd16; sb_tick = 8'd16;
    bus.rd_ready = 1'b0; bus.clear_err = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_8n1();
    test_parity();
    test_9bit();
    test_false_start();
`ifdef UART_RX_MAJORITY_EN
    test_majority();
`endif
    test_overrun();
    test_break();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
